// File: rtl/uart_tx_mmio_if.sv
// Core data-bus slice seen by the UART: byte-enabled store stream in,
// registered read data and window-hit flag out.
interface uart_tx_mmio_if;
    logic [3:0]  MemWrite_EN;
    logic [31:0] MemAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel_q;

    modport master (
        output MemWrite_EN, MemAddr, WriteData,
        input  ReadData, sel_q
    );

    modport slave (
        input  MemWrite_EN, MemAddr, WriteData,
        output ReadData, sel_q
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped buffered UART transmitter (8N1, TX FIFO, W1C overflow).
// Define UART_TX_PARITY_EN to add the optional even-parity bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           uart_txd,
    output logic           irq_tx_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    logic        hit;
    logic [1:0]  off;
    logic        wr_tx, wr_st, wr_bd;

    assign hit   = bus.MemAddr[31:4] == BASE_ADDR[31:4];
    assign off   = bus.MemAddr[3:2];
    assign wr_tx = hit && off == 2'd0 && bus.MemWrite_EN[0];
    assign wr_st = hit && off == 2'd1 && bus.MemWrite_EN[0];
    assign wr_bd = hit && off == 2'd2
                && bus.MemWrite_EN[1:0] == 2'b11;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push_ok, pop;
    logic          ovf;
    logic [15:0]   baud_div;
    logic          parity_en;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign push_ok = wr_tx && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= bus.WriteData[7:0];
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
            // full is judged before the same-cycle pop
            if (wr_tx && full)
                ovf <= 1'b1;
            else if (wr_st && bus.WriteData[3])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div  <= DIV_RST;
            parity_en <= 1'b0;
        end else begin
            if (wr_bd)
                baud_div <= (bus.WriteData[15:0] < 16'd4)
                          ? 16'd4 : bus.WriteData[15:0];
`ifdef UART_TX_PARITY_EN
            if (wr_st)
                parity_en <= bus.WriteData[4];
`endif
        end
    end

    state_t      state, state_n;
    logic [15:0] div_lat, timer;
    logic [7:0]  shreg;
    logic [2:0]  idx;
    logic        par_q;
    logic        bit_end;
    logic        txd_n;

    assign bit_end = timer == div_lat;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        txd_n   = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                txd_n = 1'b0;
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                txd_n = shreg[0];
                if (bit_end && idx == 3'd7)
                    state_n = parity_en ? state_t'(3'd3)
                                        : S_STOP;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_n = par_q;
                if (bit_end) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_lat <= '0;
            timer   <= '0;
            shreg   <= '0;
            idx     <= '0;
            par_q   <= 1'b0;
        end else if (pop) begin
            shreg   <= mem[rd_ptr];
            par_q   <= ^mem[rd_ptr];
            div_lat <= baud_div;
            timer   <= '0;
            idx     <= '0;
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                timer <= '0;
                if (state == S_DATA) begin
                    shreg <= shreg >> 1;
                    idx   <= idx + 3'd1;
                end
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

    logic [31:0] status, rd_val, rdata_q;
    logic        sel_r, txd_q, irq_q;

    always_comb begin
        status        = '0;
        status[0]     = state != S_IDLE;
        status[1]     = full;
        status[2]     = empty;
        status[3]     = ovf;
        status[4]     = parity_en;
        status[15:8]  = 8'(count);
        case (off)
            2'd1:    rd_val = status;
            2'd2:    rd_val = {16'd0, baud_div};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            sel_r   <= 1'b0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            rdata_q <= hit ? rd_val : '0;
            sel_r   <= hit;
            txd_q   <= txd_n;
            irq_q   <= empty && state == S_IDLE;
        end
    end

    assign bus.ReadData  = rdata_q;
    assign bus.sel_q     = sel_r;
    assign uart_txd      = txd_q;
    assign irq_tx_empty  = irq_q;

    logic unused_bits;
    assign unused_bits = ^{bus.MemAddr[1:0],
                           bus.WriteData[31:16],
                           bus.MemWrite_EN[3:2]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, framing, FIFO overflow,
// baud clamp, mid-frame reset and the optional parity bit.
module tb_uart_tx_mmio;

    localparam logic [31:0] A_TX = 32'h0000_1000;
    localparam logic [31:0] A_ST = 32'h0000_1004;
    localparam logic [31:0] A_BD = 32'h0000_1008;
    localparam logic [31:0] A_RS = 32'h0000_100C;

    logic clk = 1'b0;
    logic reset;
    logic uart_txd;
    logic irq_tx_empty;

    int checks   = 0;
    int failures = 0;

    uart_tx_mmio_if bus ();

    uart_tx_mmio dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .uart_txd     (uart_txd),
        .irq_tx_empty (irq_tx_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] addr,
                      input logic [3:0]  en,
                      input logic [31:0] data);
        bus.MemAddr     = addr;
        bus.MemWrite_EN = en;
        bus.WriteData   = data;
        tick();
        bus.MemWrite_EN = 4'd0;
    endtask

    task automatic rd(input  logic [31:0] addr,
                      output logic [31:0] data);
        bus.MemAddr     = addr;
        bus.MemWrite_EN = 4'd0;
        tick();
        data = bus.ReadData;
    endtask

    // Called right after the accepting TXDATA write edge.
    task automatic frame_chk(input logic [10:0] pat,
                             input int          nbits,
                             input string       tag);
        chk({tag, "_idle0"}, 32'(uart_txd), 32'd1);
        tick();
        chk({tag, "_idle1"}, 32'(uart_txd), 32'd1);
        tick();
        chk({tag, "_start_edge"}, 32'(uart_txd), 32'd0);
        for (int b = 0; b < nbits; b++) begin
            cyc(5);
            chk($sformatf("%s_bit%0d", tag, b),
                32'(uart_txd), 32'(pat[b]));
            if (b == 0)
                chk({tag, "_irq_busy"}, 32'(irq_tx_empty), 32'd0);
            if (b == nbits - 1) begin
                cyc(4);
                chk({tag, "_irq_late"}, 32'(irq_tx_empty), 32'd0);
                cyc(1);
            end else begin
                cyc(5);
            end
        end
        chk({tag, "_irq_done"}, 32'(irq_tx_empty), 32'd1);
    endtask

    logic [31:0] r;
    logic [10:0] pat;
    int          lows;

    initial begin
        bus.MemAddr     = '0;
        bus.MemWrite_EN = '0;
        bus.WriteData   = '0;
        reset = 1'b1;
        cyc(3);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_irq", 32'(irq_tx_empty), 32'd1);
        chk("rst_rdata", bus.ReadData, 32'd0);
        chk("rst_sel", 32'(bus.sel_q), 32'd0);
        reset = 1'b0;

        rd(A_ST, r);
        chk("status_reset", r, 32'h4);
        chk("sel_hit", 32'(bus.sel_q), 32'd1);
        rd(A_BD, r);
        chk("baud_reset", r, 32'd433);
        rd(A_TX, r);
        chk("txdata_read0", r, 32'd0);
        rd(A_RS, r);
        chk("reserved_read0", r, 32'd0);
        rd(32'h0000_2000, r);
        chk("miss_rdata", r, 32'd0);
        chk("miss_sel", 32'(bus.sel_q), 32'd0);

        wr(A_BD, 4'hF, 32'd9);
        rd(A_BD, r);
        chk("baud_9", r, 32'd9);

        wr(A_TX, 4'h1, 32'h55);
        pat = 11'h2AA;
        frame_chk(pat, 10, "f55");
        rd(A_ST, r);
        chk("status_after_f55", r, 32'h4);

        for (int k = 0; k < 17; k++)
            wr(A_TX, 4'h1, 32'(k));
        rd(A_ST, r);
        chk("status_17_full", r, 32'h1003);
        wr(A_TX, 4'h1, 32'hEE);
        rd(A_ST, r);
        chk("status_ovf", r, 32'h100B);
        wr(A_ST, 4'h1, 32'h0);
        rd(A_ST, r);
        chk("ovf_kept", r, 32'h100B);
        wr(A_ST, 4'h1, 32'h8);
        rd(A_ST, r);
        chk("ovf_clear", r, 32'h1003);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(A_ST, r);
        chk("status_rst2", r, 32'h4);
        rd(A_BD, r);
        chk("baud_rst2", r, 32'd433);

        wr(A_BD, 4'hF, 32'd1);
        rd(A_BD, r);
        chk("baud_clamp1", r, 32'd4);
        wr(A_BD, 4'h1, 32'h20);
        rd(A_BD, r);
        chk("baud_partial_lo", r, 32'd4);
        wr(A_BD, 4'h3, 32'd5);
        rd(A_BD, r);
        chk("baud_en11", r, 32'd5);
        wr(A_BD, 4'h2, 32'h40);
        rd(A_BD, r);
        chk("baud_partial_hi", r, 32'd5);
        wr(A_BD, 4'hF, 32'd3);
        rd(A_BD, r);
        chk("baud_clamp3", r, 32'd4);
        wr(A_BD, 4'hF, 32'h0001_0009);
        rd(A_BD, r);
        chk("baud_upper_ign", r, 32'd9);

        wr(A_TX, 4'h1, 32'hA3);
        wr(A_TX, 4'h1, 32'h00);
        cyc(26);
        chk("a3_bit1", 32'(uart_txd), 32'd1);
        cyc(8);
        chk("a3_bit2", 32'(uart_txd), 32'd0);
        reset = 1'b1;
        tick();
        chk("midrst_txd", 32'(uart_txd), 32'd1);
        chk("midrst_irq", 32'(irq_tx_empty), 32'd1);
        reset = 1'b0;
        rd(A_ST, r);
        chk("midrst_status", r, 32'h4);
        lows = 0;
        repeat (150) begin
            tick();
            if (uart_txd !== 1'b1) lows++;
        end
        chk("midrst_quiet", 32'(lows), 32'd0);

        wr(A_BD, 4'hF, 32'd9);
        wr(A_ST, 4'h1, 32'h10);
        rd(A_ST, r);
`ifdef UART_TX_PARITY_EN
        chk("parity_en_rd", r, 32'h14);
        wr(A_TX, 4'h1, 32'h07);
        pat = 11'h60E;
        frame_chk(pat, 11, "f07p");
`else
        chk("parity_absent", r, 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
